// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, PAYLOAD[LEN], CHK with XOR check and valid/ack hand-off.
// Define FRAME_TIMEOUT_EN to build the inter-byte timeout; without it err_timeout_o is tied low.
module uart_frame_parser #(
    parameter logic [7:0]   SYNC_BYTE    = 8'hA5,
    parameter int unsigned  MAX_LEN      = 16,
    parameter int unsigned  TIMEOUT_CLKS = 100_000,
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1),
    localparam int unsigned ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              frame_valid_o,
    input  logic              frame_ack_i,
    output logic [7:0]        frame_cmd_o,
    output logic [LEN_W-1:0]  frame_len_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              err_chk_o,
    output logic              err_len_o,
    output logic              err_drop_o,
    output logic              err_timeout_o
);

    // state     | meaning
    // S_HUNT    | discarding bytes until SYNC_BYTE
    // S_CMD     | next byte is CMD
    // S_LEN     | next byte is LEN
    // S_PAYLOAD | storing payload bytes, then the CHK byte
    // S_HOLD    | good frame presented, waiting for ack
    typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       chk_q, chk_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_drop_q, err_drop_d;
    logic [7:0]       buf_q [2**ADDR_W];
    logic             buf_we;
    logic             is_sync, len_bad, payload_done, chk_ok, timeout_hit;

    assign is_sync      = (in_data_i == SYNC_BYTE);
    assign len_bad      = (32'(in_data_i) > MAX_LEN);
    assign payload_done = (cnt_q == len_q);
    assign chk_ok       = (in_data_i == chk_q);

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned     TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] idle_q, idle_d;
    logic            in_frame;
    logic            err_timeout_q;

    assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) || (state_q == S_PAYLOAD);

    // Down-counter reloads on every byte and whenever no frame is open.
    always_comb begin
        idle_d = idle_q;
        if (!in_frame || in_valid_i) begin
            idle_d = TO_RELOAD;
        end else if (idle_q != '0) begin
            idle_d = idle_q - 1'b1;
        end
    end

    assign timeout_hit = in_frame && !in_valid_i && (idle_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_q        <= TO_RELOAD;
            err_timeout_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            err_timeout_q <= timeout_hit;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT: begin
                if (in_valid_i && is_sync) state_d = S_CMD;
            end
            S_CMD: begin
                if (in_valid_i) state_d = S_LEN;
            end
            S_LEN: begin
                if (in_valid_i) state_d = len_bad ? S_HUNT : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (in_valid_i && payload_done) state_d = chk_ok ? S_HOLD : S_HUNT;
            end
            S_HOLD: begin
                // An ack frees the parser in time to treat a same-cycle byte as a hunt byte.
                if (frame_ack_i) state_d = (in_valid_i && is_sync) ? S_CMD : S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase
        if (timeout_hit) state_d = S_HUNT;
    end

    always_comb begin
        cmd_d      = cmd_q;
        chk_d      = chk_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        buf_we     = 1'b0;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_drop_d = 1'b0;
        if (in_valid_i) begin
            case (state_q)
                S_CMD: begin
                    cmd_d = in_data_i;
                    chk_d = in_data_i;
                end
                S_LEN: begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                    end else begin
                        len_d = LEN_W'(in_data_i);
                        chk_d = chk_q ^ in_data_i;
                        cnt_d = '0;
                    end
                end
                S_PAYLOAD: begin
                    if (!payload_done) begin
                        buf_we = 1'b1;
                        chk_d  = chk_q ^ in_data_i;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (!chk_ok) begin
                        err_chk_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!frame_ack_i) err_drop_d = 1'b1;
                end
                default: ;
            endcase
        end

        frame_valid_o = (state_q == S_HOLD);
        frame_cmd_o   = cmd_q;
        frame_len_o   = len_q;
        rd_data_o     = buf_q[rd_addr_i];
        err_chk_o     = err_chk_q;
        err_len_o     = err_len_q;
        err_drop_o    = err_drop_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q      <= '0;
            chk_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            chk_q      <= chk_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_drop_q <= err_drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we && !rst_i) buf_q[ADDR_W'(cnt_q)] <= in_data_i;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed vector table, hand-written corner sequences,
// and a randomized byte stream compared against a frame-level queue model.
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TO_CLKS = 50;
    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam int          LEN_W   = $clog2(MAX_LEN + 1);
    localparam int          ADDR_W  = $clog2(MAX_LEN);
    localparam logic [3:0]  E_NONE  = 4'b0000;
    localparam logic [3:0]  E_CHK   = 4'b0001;
    localparam logic [3:0]  E_LEN   = 4'b0010;
    localparam logic [3:0]  E_DROP  = 4'b0100;
    localparam logic [3:0]  E_TO    = 4'b1000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [7:0]        in_data_i;
    logic              in_valid_i;
    logic              frame_valid_o;
    logic              frame_ack_i;
    logic [7:0]        frame_cmd_o;
    logic [LEN_W-1:0]  frame_len_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [7:0]        rd_data_o;
    logic              err_chk_o;
    logic              err_len_o;
    logic              err_drop_o;
    logic              err_timeout_o;

    always #5 clk_i = ~clk_i;

    uart_frame_parser #(
        .SYNC_BYTE   (SYNC),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CLKS(TO_CLKS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .frame_valid_o(frame_valid_o),
        .frame_ack_i  (frame_ack_i),
        .frame_cmd_o  (frame_cmd_o),
        .frame_len_o  (frame_len_o),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .err_chk_o    (err_chk_o),
        .err_len_o    (err_len_o),
        .err_drop_o   (err_drop_o),
        .err_timeout_o(err_timeout_o)
    );

    typedef struct {
        bit                v;
        logic [7:0]        d;
        bit                ack;
        logic [ADDR_W-1:0] ra;
        bit                crd;
        logic [7:0]        rd;
        bit                ev;
        logic [7:0]        ecmd;
        int                elen;
        logic [3:0]        eerr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] good_pl [3] = '{8'h11, 8'h22, 8'h33};

    // Frame-level reference model: bytes after a sync are collected and judged once complete.
    bit         m_pend;
    bit         m_coll;
    logic [7:0] m_cmd;
    int         m_len;
    logic [7:0] m_pl [MAX_LEN];
    logic [7:0] m_cur [$];
    int         m_idle;
    logic [3:0] m_err;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void expect_out(string tag, bit ev, logic [7:0] ecmd, int elen,
                                       logic [3:0] eerr, bit crd, logic [7:0] erd);
        check({tag, " frame_valid"}, int'(frame_valid_o), int'(ev));
        check({tag, " err_chk"},     int'(err_chk_o),     int'(eerr[0]));
        check({tag, " err_len"},     int'(err_len_o),     int'(eerr[1]));
        check({tag, " err_drop"},    int'(err_drop_o),    int'(eerr[2]));
        check({tag, " err_timeout"}, int'(err_timeout_o), int'(eerr[3]));
        if (ev) begin
            check({tag, " frame_cmd"}, int'(frame_cmd_o), int'(ecmd));
            check({tag, " frame_len"}, int'(frame_len_o), elen);
        end
        if (crd) check({tag, " rd_data"}, int'(rd_data_o), int'(erd));
    endfunction

    function automatic void expect_reset(string tag);
        expect_out(tag, 1'b0, 8'h00, 0, E_NONE, 1'b0, 8'h00);
        check({tag, " frame_cmd reset"}, int'(frame_cmd_o), 0);
        check({tag, " frame_len reset"}, int'(frame_len_o), 0);
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit ack, input logic [ADDR_W-1:0] ra);
        in_valid_i  = v;
        in_data_i   = d;
        frame_ack_i = ack;
        rd_addr_i   = ra;
        @(negedge clk_i);
    endtask

    function automatic void push(bit v, logic [7:0] d, bit ack, logic [ADDR_W-1:0] ra, bit crd,
                                 logic [7:0] rd, bit ev, logic [7:0] ecmd, int elen, logic [3:0] eerr);
        vec_t r;
        r.v = v; r.d = d; r.ack = ack; r.ra = ra; r.crd = crd; r.rd = rd;
        r.ev = ev; r.ecmd = ecmd; r.elen = elen; r.eerr = eerr;
        tbl.push_back(r);
    endfunction

    function automatic void byt(logic [7:0] d, bit ack, bit ev, logic [7:0] ecmd, int elen, logic [3:0] eerr);
        push(1'b1, d, ack, '0, 1'b0, 8'h00, ev, ecmd, elen, eerr);
    endfunction

    function automatic void b0(logic [7:0] d);
        byt(d, 1'b0, 1'b0, 8'h00, 0, E_NONE);
    endfunction

    function automatic void idl(bit ack, bit ev, logic [7:0] ecmd, int elen, logic [3:0] eerr);
        push(1'b0, 8'h00, ack, '0, 1'b0, 8'h00, ev, ecmd, elen, eerr);
    endfunction

    function automatic void rdc(logic [ADDR_W-1:0] ra, logic [7:0] rd, logic [7:0] ecmd, int elen);
        push(1'b0, 8'h00, 1'b0, ra, 1'b1, rd, 1'b1, ecmd, elen, E_NONE);
    endfunction

    function automatic void model_reset();
        m_pend = 1'b0;
        m_coll = 1'b0;
        m_cur.delete();
        m_idle = 0;
        m_err  = E_NONE;
        m_cmd  = 8'h00;
        m_len  = 0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit ack);
        logic [7:0] x;
        m_err = E_NONE;
        if (m_pend) begin
            if (ack) begin
                m_pend = 1'b0;
                if (v && d == SYNC) begin
                    m_coll = 1'b1;
                    m_cur.delete();
                    m_idle = 0;
                end
            end else if (v) begin
                m_err = E_DROP;
            end
        end else if (m_coll) begin
            if (v) begin
                m_idle = 0;
                m_cur.push_back(d);
                if (m_cur.size() == 2 && m_cur[1] > MAX_LEN) begin
                    m_err  = E_LEN;
                    m_coll = 1'b0;
                end else if (m_cur.size() >= 2 && m_cur.size() == int'(m_cur[1]) + 3) begin
                    x = 8'h00;
                    for (int i = 0; i < m_cur.size() - 1; i++) x ^= m_cur[i];
                    if (x == m_cur[m_cur.size() - 1]) begin
                        m_pend = 1'b1;
                        m_cmd  = m_cur[0];
                        m_len  = int'(m_cur[1]);
                        for (int i = 0; i < m_len; i++) m_pl[i] = m_cur[i + 2];
                    end else begin
                        m_err = E_CHK;
                    end
                    m_coll = 1'b0;
                end
            end
`ifdef FRAME_TIMEOUT_EN
            else begin
                m_idle++;
                if (m_idle == int'(TO_CLKS)) begin
                    m_err  = E_TO;
                    m_coll = 1'b0;
                end
            end
`endif
        end else if (v && d == SYNC) begin
            m_coll = 1'b1;
            m_cur.delete();
            m_idle = 0;
        end
    endfunction

    task automatic rnd_cycle(input bit v, input logic [7:0] d);
        bit                ack;
        logic [ADDR_W-1:0] ra;
        ack = ($urandom_range(0, 3) == 0);
        ra  = ADDR_W'($urandom_range(0, MAX_LEN - 1));
        model_step(v, d, ack);
        drive(v, d, ack, ra);
        expect_out("rnd", m_pend, m_cmd, m_len, m_err, m_pend && (int'(ra) < m_len), m_pl[ra]);
    endtask

    initial begin
        #(10_000_000);
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        frame_ack_i = 1'b0;
        rd_addr_i   = '0;

        // good frame preceded by noise, read back, ack
        b0(8'h00); b0(8'hFF); b0(SYNC); b0(8'h01); b0(8'h03); b0(8'h11); b0(8'h22); b0(8'h33);
        byt(8'h02, 1'b0, 1'b1, 8'h01, 3, E_NONE);
        rdc(0, 8'h11, 8'h01, 3); rdc(1, 8'h22, 8'h01, 3); rdc(2, 8'h33, 8'h01, 3);
        idl(1'b1, 1'b0, 8'h00, 0, E_NONE);
        // bad checksum then a good frame
        b0(SYNC); b0(8'h01); b0(8'h03); b0(8'h11); b0(8'h22); b0(8'h33);
        byt(8'h03, 1'b0, 1'b0, 8'h00, 0, E_CHK);
        idl(1'b0, 1'b0, 8'h00, 0, E_NONE);
        b0(SYNC); b0(8'h09); b0(8'h01); b0(8'h44);
        byt(8'h4C, 1'b0, 1'b1, 8'h09, 1, E_NONE);
        rdc(0, 8'h44, 8'h09, 1);
        idl(1'b1, 1'b0, 8'h00, 0, E_NONE);
        // zero length, drop while pending, ack+sync same cycle
        b0(SYNC); b0(8'h07); b0(8'h00);
        byt(8'h07, 1'b0, 1'b1, 8'h07, 0, E_NONE);
        byt(SYNC, 1'b0, 1'b1, 8'h07, 0, E_DROP);
        idl(1'b0, 1'b1, 8'h07, 0, E_NONE);
        byt(SYNC, 1'b1, 1'b0, 8'h00, 0, E_NONE);
        b0(8'h05); b0(8'h00);
        byt(8'h05, 1'b0, 1'b1, 8'h05, 0, E_NONE);
        idl(1'b1, 1'b0, 8'h00, 0, E_NONE);
        // oversize length; an oversize LEN equal to SYNC must not resync
        b0(SYNC); b0(8'h07);
        byt(8'h11, 1'b0, 1'b0, 8'h00, 0, E_LEN);
        idl(1'b0, 1'b0, 8'h00, 0, E_NONE);
        b0(SYNC); b0(8'h07);
        byt(SYNC, 1'b0, 1'b0, 8'h00, 0, E_LEN);
        b0(8'h01); b0(SYNC); b0(8'h02);
        byt(8'h00, 1'b1, 1'b0, 8'h00, 0, E_NONE);
        byt(8'h02, 1'b0, 1'b1, 8'h02, 0, E_NONE);
        idl(1'b1, 1'b0, 8'h00, 0, E_NONE);
        // sync value inside payload is data; max-length boundary follows in random phase
        b0(SYNC); b0(8'h03); b0(8'h02); b0(SYNC); b0(SYNC);
        byt(8'h01, 1'b0, 1'b1, 8'h03, 2, E_NONE);
        rdc(0, SYNC, 8'h03, 2); rdc(1, SYNC, 8'h03, 2);
        idl(1'b1, 1'b0, 8'h00, 0, E_NONE);

        repeat (2) @(negedge clk_i);
        expect_reset("reset");
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].ack, tbl[i].ra);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ecmd, tbl[i].elen,
                       tbl[i].eerr, tbl[i].crd, tbl[i].rd);
        end

        // reset in the middle of a payload
        drive(1'b1, SYNC, 1'b0, '0); drive(1'b1, 8'h01, 1'b0, '0);
        drive(1'b1, 8'h03, 1'b0, '0); drive(1'b1, 8'h11, 1'b0, '0);
        rst_i = 1'b1;
        drive(1'b0, 8'h00, 1'b0, '0);
        rst_i = 1'b0;
        expect_reset("midreset");
        drive(1'b1, SYNC, 1'b0, '0); drive(1'b1, 8'h01, 1'b0, '0); drive(1'b1, 8'h03, 1'b0, '0);
        drive(1'b1, 8'h11, 1'b0, '0); drive(1'b1, 8'h22, 1'b0, '0); drive(1'b1, 8'h33, 1'b0, '0);
        drive(1'b1, 8'h02, 1'b0, '0);
        expect_out("postreset", 1'b1, 8'h01, 3, E_NONE, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, ADDR_W'(i));
            expect_out($sformatf("postreset rd%0d", i), 1'b1, 8'h01, 3, E_NONE, 1'b1, good_pl[i]);
        end
        drive(1'b0, 8'h00, 1'b1, '0);
        expect_out("postreset ack", 1'b0, 8'h00, 0, E_NONE, 1'b0, 8'h00);

        // stall after CMD for the timeout interval
        drive(1'b1, SYNC, 1'b0, '0);
        drive(1'b1, 8'h01, 1'b0, '0);
        for (int i = 1; i <= int'(TO_CLKS) + 1; i++) begin
            drive(1'b0, 8'h00, 1'b0, '0);
`ifdef FRAME_TIMEOUT_EN
            expect_out($sformatf("idle%0d", i), 1'b0, 8'h00, 0,
                       (i == int'(TO_CLKS)) ? E_TO : E_NONE, 1'b0, 8'h00);
`else
            expect_out($sformatf("idle%0d", i), 1'b0, 8'h00, 0, E_NONE, 1'b0, 8'h00);
`endif
        end
`ifdef FRAME_TIMEOUT_EN
        drive(1'b1, SYNC, 1'b0, '0); drive(1'b1, 8'h01, 1'b0, '0); drive(1'b1, 8'h03, 1'b0, '0);
        drive(1'b1, 8'h11, 1'b0, '0); drive(1'b1, 8'h22, 1'b0, '0); drive(1'b1, 8'h33, 1'b0, '0);
        drive(1'b1, 8'h02, 1'b0, '0);
        expect_out("after timeout", 1'b1, 8'h01, 3, E_NONE, 1'b0, 8'h00);
`else
        drive(1'b1, 8'h00, 1'b0, '0);
        drive(1'b1, 8'h01, 1'b0, '0);
        expect_out("after stall", 1'b1, 8'h01, 0, E_NONE, 1'b0, 8'h00);
`endif
        drive(1'b0, 8'h00, 1'b1, '0);
        expect_out("stall ack", 1'b0, 8'h00, 0, E_NONE, 1'b0, 8'h00);

        // randomized stream against the frame-level model
        rst_i = 1'b1;
        drive(1'b0, 8'h00, 1'b0, '0);
        rst_i = 1'b0;
        model_reset();
        expect_reset("rnd reset");
        for (int f = 0; f < 250; f++) begin : frm
            logic [7:0] q [$];
            logic [7:0] x;
            int         kind;
            int         len;
            int         gap;
            q.delete();
            kind = $urandom_range(0, 5);
            len  = $urandom_range(0, MAX_LEN);
            x    = 8'h00;
            case (kind)
                0, 1, 2, 5: begin
                    q.push_back(SYNC);
                    q.push_back(8'($urandom));
                    q.push_back(8'(len));
                    for (int i = 0; i < len; i++)
                        q.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
                    for (int i = 1; i < q.size(); i++) x ^= q[i];
                    if (kind == 1) x ^= 8'($urandom_range(1, 255));
                    if (kind != 5) q.push_back(x);
                end
                3: begin
                    q.push_back(SYNC);
                    q.push_back(8'($urandom));
                    q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
                end
                default: begin
                    for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
                end
            endcase
            foreach (q[i]) begin
                gap = ($urandom_range(0, 19) == 0) ? $urandom_range(40, 55) : $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) rnd_cycle(1'b0, 8'($urandom));
                rnd_cycle(1'b1, q[i]);
            end
            if (kind == 5) begin
                for (int g = 0; g < 55; g++) rnd_cycle(1'b0, 8'h00);
            end
        end
        for (int g = 0; g < 60; g++) rnd_cycle(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (`in_data` / `in_valid`, one-cycle strobes, no backpressure).
- Hunts for a sync byte, then parses a frame of the form SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
- Verifies an XOR checksum and presents each good frame (cmd, len, buffered payload) to the command layer through a valid/ack handshake.

Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload bytes; sets buffer depth (>=1).
- `TIMEOUT_CLKS`, 100_000: maximum idle clocks between bytes inside a frame (used only with `FRAME_TIMEOUT_EN`).
- `LEN_W` (localparam) = $clog2(MAX_LEN+1); `ADDR_W` (localparam) = $clog2(MAX_LEN), minimum 1.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  8  received byte
- `in_valid`  in  1  one-cycle strobe, `in_data` valid
- `frame_valid`  out  1  good frame pending; held until acked
- `frame_ack`  in  1  consumer releases pending frame
- `frame_cmd`  out  8  CMD byte of pending frame
- `frame_len`  out  LEN_W  payload length of pending frame
- `rd_addr`  in  ADDR_W  payload buffer read index
- `rd_data`  out  8  buffer[`rd_addr`], combinational read
- `err_chk`  out  1  one-cycle pulse: checksum mismatch
- `err_len`  out  1  one-cycle pulse: LEN > `MAX_LEN`
- `err_drop`  out  1  one-cycle pulse: byte discarded while frame pending
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout

Behaviour:
- Reset: state=HUNT. `frame_valid`, `frame_cmd`, `frame_len` and all `err_*` are 0; checksum accumulator 0; payload count 0. Buffer contents are not reset.
- States: HUNT, CMD, LEN, PAYLOAD, HOLD. Transitions occur only on `in_valid`, except HOLD→HUNT on ack and timeout aborts.
- HUNT: on a byte == `SYNC_BYTE` → CMD; any other byte is ignored silently.
- CMD: latch `frame_cmd`; chk = byte → LEN.
- LEN:
  - byte > `MAX_LEN`: pulse `err_len`, → HUNT; the byte is not re-examined as sync.
  - otherwise latch `frame_len`; chk ^= byte; count = 0; → PAYLOAD.
- PAYLOAD:
  - While count < `frame_len`: buffer[count] = byte; chk ^= byte; count++.
  - Once count == `frame_len` (immediately when LEN=0), the next byte is CHK.
  - CHK == chk → HOLD. CHK != chk → pulse `err_chk`, → HUNT.
  - A `SYNC_BYTE` value inside the payload is treated as data; no resync.
- HOLD:
  - `frame_valid` = 1 from the cycle after the CHK strobe (latency 1).
  - `frame_cmd`, `frame_len` and buffer are stable while `frame_valid` is high.
  - `frame_ack`=1 → `frame_valid`=0 next cycle, → HUNT.
  - `in_valid` with no ack: pulse `err_drop`, byte discarded.
  - Same-cycle `frame_ack` and `in_valid`: the byte is evaluated as in HUNT, so a sync byte moves directly to CMD and `err_drop` is not pulsed.
- `frame_ack` outside HOLD is ignored.
- `rd_addr` >= `frame_len` returns stale buffer data (defined but unspecified value).
- Error pulses are high exactly one cycle, the cycle after the offending strobe. At most one `err_*` is high in any cycle.
- Reset mid-frame: frame discarded; no error pulse; `frame_valid` low on the following cycle.
- Checksum arithmetic: 8-bit XOR over CMD, LEN and all payload bytes. The SYNC byte is excluded.

Optional Feature:
- Macro: `FRAME_TIMEOUT_EN`.
- Defined:
  - An idle counter of width $clog2(`TIMEOUT_CLKS`) clears on every `in_valid` and counts in CMD, LEN and PAYLOAD.
  - On reaching `TIMEOUT_CLKS`-1 with no byte: pulse `err_timeout`, → HUNT.
  - The counter is held at 0 in HUNT and HOLD.
  - If `in_valid` arrives in the same cycle the limit is reached, the byte wins and no timeout occurs.
- Not defined: no counter is built; `err_timeout` is tied 0; a stalled frame waits indefinitely.

Test Plan:
- Good frame: stream 00, FF, A5, 01, 03, 11, 22, 33, 02 → `frame_valid`=1 one cycle after the 02 strobe; `frame_cmd`=01, `frame_len`=3; `rd_data` at addr 0/1/2 = 11/22/33; no `err_*`. Pulse `frame_ack` → `frame_valid`=0 next cycle.
- Bad checksum: A5, 01, 03, 11, 22, 33, 03 → `err_chk` single-cycle pulse; `frame_valid` stays 0; a following good frame is accepted.
- Zero length: A5, 07, 00, 07 → `frame_valid`, `frame_cmd`=07, `frame_len`=0. Length 17 (`MAX_LEN`=16): A5, 07, 11 → `err_len` pulse, back to HUNT.
- Pending frame: after a good frame with no ack, send A5 → `err_drop` pulse; the pending frame is unchanged. Then send A5 with `frame_ack` in the same cycle, followed by 05, 00, 05 → no `err_drop`; new frame with `frame_cmd`=05 valid.
- Timeout (`FRAME_TIMEOUT_EN`, `TIMEOUT_CLKS`=50): A5, 01, then idle 50 clocks → `err_timeout` pulse; a subsequent full good frame parses correctly. Without the macro, the same idle gap produces no pulse.
- Reset asserted one clock mid-PAYLOAD → all outputs at reset values next cycle; a subsequent good frame parses correctly.
